// File: rtl/fp_mant_normalize_round_if.sv
// ----------------------------------------------------------------------------
// fp_mant_normalize_round_if
// Handshake bundle for the significand normalize/round stage.
//   Upstream side  : in_valid, in_ready, in_mant[MW], in_exp[EW]
//   Downstream side: out_valid, out_ready, out_mant[OW], out_exp[EW],
//                    out_zero, out_ovf, out_unf
// Modports:
//   master : the environment (drives inputs and out_ready, observes results)
//   slave  : the stage itself
// ----------------------------------------------------------------------------
interface fp_mant_normalize_round_if #(
    parameter int MW = 48,
    parameter int OW = 24,
    parameter int EW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_mant;
    logic [EW-1:0] in_exp;

    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_mant;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_ovf;
    logic          out_unf;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_mant_normalize_round.sv
// ----------------------------------------------------------------------------
// fp_mant_normalize_round
// Multi-cycle post-adder / post-multiplier stage. Takes a raw MW-bit
// significand in [0,4) (binary point between bits MW-2 and MW-3) with a
// signed biased working exponent, normalizes it one bit position per cycle
// so that bit MW-2 is the leading one, then rounds to OW bits (hidden bit
// included) with round-to-nearest-even.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of fp_mant_normalize_round_if (valid/ready in and out)
// Timing: one operation in flight; in_ready only in IDLE, out_valid only in
// DONE. Latency from the accept edge is 2 + shifts, or a direct jump to DONE
// for a zero significand.
// ----------------------------------------------------------------------------
module fp_mant_normalize_round #(
    parameter int MW   = 48,
    parameter int OW   = 24,
    parameter int EW   = 10,
    parameter int EMAX = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    fp_mant_normalize_round_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [OW-1:0] MANT_ONE = {1'b1, {(OW-1){1'b0}}};

    state_t        state_q, state_d;
    logic [MW-1:0] m_q, m_d;        // working significand
    logic [EW-1:0] e_q, e_d;        // working exponent
    logic          s_q, s_d;        // sticky from the single right shift
    logic [OW-1:0] mant_q, mant_d;
    logic [EW-1:0] exp_q, exp_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // Rounding fields, valid once bit MW-2 holds the leading one.
    logic [OW-1:0] keep;
    logic          guard;
    logic          sticky;
    logic          round_up;
    logic [OW:0]   keep_inc;
    logic          round_carry;
    logic [EW-1:0] fin_exp;
    logic          ovf_flag;
    logic          unf_flag;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            mant_q  <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            s_q     <= s_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Rounding arithmetic (round-to-nearest-even on the normalized value)
    // ------------------------------------------------------------------------
    always_comb begin
        keep        = m_q[MW-2 -: OW];
        guard       = m_q[MW-2-OW];
        sticky      = s_q | (|m_q[MW-3-OW:0]);
        // Exact ties round up only when the kept LSB is odd.
        round_up    = guard & (sticky | keep[0]);
        keep_inc    = {1'b0, keep} + {{OW{1'b0}}, round_up};
        round_carry = keep_inc[OW];
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        s_d     = s_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        fin_exp = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d = bus.in_mant;
                    e_d = bus.in_exp;
                    s_d = 1'b0;
                    if (bus.in_mant == '0) begin
                        // Zero skips normalization; result exponent is 0.
                        state_d = DONE;
                        fin_exp = '0;
                        mant_d  = '0;
                        exp_d   = '0;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (m_q[MW-1]) begin
                    // Value in [2,4): one right shift, remember the lost bit.
                    m_d = {1'b0, m_q[MW-1:1]};
                    e_d = e_q + EW'(1);
                    s_d = s_q | m_q[0];
                end else if (!m_q[MW-2]) begin
                    m_d = {m_q[MW-2:0], 1'b0};
                    e_d = e_q - EW'(1);
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                // An all-ones keep field that rounds up becomes 1.0 * 2^(e+1).
                fin_exp = round_carry ? (e_q + EW'(1)) : e_q;
                mant_d  = round_carry ? MANT_ONE : keep_inc[OW-1:0];
                exp_d   = fin_exp;
                zero_d  = 1'b0;
                state_d = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Flags follow the exponent being written in this cycle.
        ovf_flag = (int'($signed(fin_exp)) >= EMAX);
        unf_flag = (int'($signed(fin_exp)) <= 0);
        if ((state_q == ROUND) || ((state_q == IDLE) && bus.in_valid && (bus.in_mant == '0))) begin
            ovf_d = ovf_flag;
            unf_d = unf_flag;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_mant  = mant_q;
    assign bus.out_exp   = exp_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_unf   = unf_q;

endmodule

// File: tb/tb_fp_mant_normalize_round.sv
// ----------------------------------------------------------------------------
// tb_fp_mant_normalize_round
// Directed and randomized checks of fp_mant_normalize_round against an
// arithmetic reference model (leading-one position, integer remainder
// comparison for round-to-nearest-even).
// ----------------------------------------------------------------------------
module tb_fp_mant_normalize_round;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fp_mant_normalize_round_if #(.MW(48), .OW(24), .EW(10)) bus_if ();

    fp_mant_normalize_round #(.MW(48), .OW(24), .EW(10), .EMAX(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: value = mant * 2^-46 * 2^exp. Locate the leading one, scale
    // to a 24-bit integer significand, round the discarded part to nearest
    // even by comparing it with one half ulp.
    task automatic model(input logic [47:0] mant, input logic [9:0] ex,
                         output logic [23:0] om, output logic [9:0] oe,
                         output logic oz, output logic ovf, output logic unf,
                         output int lat);
        int          p;
        int          ee;
        int          sh;
        logic [63:0] keep;
        logic [63:0] rem;
        logic [63:0] half;
        logic [63:0] wide;
        if (mant == 48'd0) begin
            om  = '0;
            oe  = '0;
            oz  = 1'b1;
            ovf = 1'b0;
            unf = 1'b1;   // exponent 0 counts as underflow
            lat = 0;      // valid in the very first cycle after acceptance
        end else begin
            p = 47;
            while (p > 0 && !mant[p]) p--;
            ee   = int'($signed(ex)) + (p - 46);
            lat  = 2 + ((p > 46) ? (p - 46) : (46 - p));
            wide = {16'd0, mant};
            if (p >= 23) begin
                sh   = p - 23;
                keep = wide >> sh;
                rem  = wide & ((64'd1 << sh) - 64'd1);
                half = (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
                if (sh > 0 && (rem > half || (rem == half && keep[0])))
                    keep = keep + 64'd1;
            end else begin
                keep = wide << (23 - p);
            end
            if (keep == (64'd1 << 24)) begin
                keep = 64'd1 << 23;
                ee   = ee + 1;
            end
            om  = keep[23:0];
            oe  = 10'(ee);
            oz  = 1'b0;
            ovf = (ee >= 255);
            unf = (ee <= 0);
        end
    endtask

    task automatic run_op(input string tag, input logic [47:0] mant, input logic [9:0] ex, input int hold);
        logic [23:0] em;
        logic [9:0]  ee;
        logic        ez;
        logic        eo;
        logic        eu;
        int          el;
        int          lat;
        model(mant, ex, em, ee, ez, eo, eu, el);

        @(negedge clk);
        check({tag, ":in_ready_idle"}, 64'(bus_if.in_ready), 64'd1);
        bus_if.in_valid  = 1'b1;
        bus_if.in_mant   = mant;
        bus_if.in_exp    = ex;
        bus_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Keep offering junk while busy; it must be ignored.
        bus_if.in_mant = 48'({$urandom, $urandom});
        bus_if.in_exp  = 10'($urandom);
        lat = 0;
        while (!bus_if.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, 64'(lat), 64'(el));

        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        check({tag, ":valid_held"}, {62'd0, bus_if.out_valid, bus_if.in_ready}, 64'b10);
        check({tag, ":mant"}, 64'(bus_if.out_mant), 64'(em));
        check({tag, ":exp"},  64'(bus_if.out_exp),  64'(ee));
        check({tag, ":flags"}, {61'd0, bus_if.out_zero, bus_if.out_ovf, bus_if.out_unf},
              {61'd0, ez, eo, eu});

        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ":release"}, {62'd0, bus_if.out_valid, bus_if.in_ready}, 64'b01);
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        logic [47:0] rm;
        logic [9:0]  rx;
        logic [23:0] rk;
        checks = 0;
        errors = 0;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_mant   = '0;
        bus_if.in_exp    = '0;
        bus_if.out_ready = 1'b0;
        #1;
        check("reset:handshake", {62'd0, bus_if.in_ready, bus_if.out_valid}, 64'b10);
        check("reset:outputs", {bus_if.out_mant, bus_if.out_exp, bus_if.out_zero,
                                bus_if.out_ovf, bus_if.out_unf}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("T1", 48'h4000_0000_0000, 10'd127, 0);
        run_op("T2", 48'h8000_0000_0000, 10'd127, 0);
        run_op("T3", 48'h0000_0000_0001, 10'd127, 0);
        run_op("T4_carry", 48'h7FFF_FFC0_0000, 10'd127, 1);
        run_op("T4_tie_even", 48'h4000_0040_0000, 10'd127, 0);
        run_op("T4_sticky", 48'h4000_0040_0001, 10'd127, 0);
        run_op("T4_tie_odd", 48'h4000_00C0_0000, 10'd127, 0);
        run_op("T2_sticky", 48'hC000_0100_0001, 10'd100, 0);
        run_op("T5_zero", 48'h0, 10'd77, 2);
        run_op("T5_ovf", 48'h8000_0000_0000, 10'd254, 10);
        run_op("unf", 48'h0000_0000_0001, 10'd10, 0);
        run_op("unf_edge", 48'h2000_0000_0000, 10'd1, 0);

        // T6: reset five cycles into a long normalization.
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_mant  = 48'h0000_0000_0001;
        bus_if.in_exp   = 10'd127;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("T6:busy_before_rst", 64'(bus_if.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("T6:rst_mid_op", {62'd0, bus_if.in_ready, bus_if.out_valid}, 64'b10);
        @(negedge clk);
        rst = 1'b0;
        run_op("T6_T1", 48'h4000_0000_0000, 10'd127, 0);

        // Reset while a result is being offered drops it at once.
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_mant  = 48'h0;
        bus_if.in_exp   = 10'd5;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check("rst_done:valid_before", 64'(bus_if.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_done:valid_after", {62'd0, bus_if.in_ready, bus_if.out_valid}, 64'b10);
        @(negedge clk);
        rst = 1'b0;

        // Randomized: arbitrary leading-one positions, plus exact ties.
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 3) begin
                rk = 24'($urandom) | 24'h800000;
                rm = (48'(rk) << 23) | 48'h0000_0040_0000;
            end else begin
                rm = 48'({$urandom, $urandom}) >> $urandom_range(0, 47);
            end
            rx = 10'(int'($urandom_range(0, 511)) - 256);
            run_op($sformatf("rnd%0d", i), rm, rx, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
